// File: rtl/det_share_pkg.sv
// Shared types and constants for the time-shared sequence detector scheduler.
package det_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Cycles between the final forwarded byte and the detector flag being valid:
  // one for the det_in register, one for the detector's own state/out register.
  localparam int DRAIN_CYCLES = 2;

  // Byte sequence recognised by the shared detector.
  localparam logic [7:0] SEQ_BYTE0 = 8'h1F;
  localparam logic [7:0] SEQ_BYTE1 = 8'hB2;
  localparam logic [7:0] SEQ_BYTE2 = 8'h3C;

endpackage

// File: rtl/det_share_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  int   idx_s;
  logic found_s;

  // Scan requesters starting at the pointer and keep only the first one seen
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = (int'(ptr) + i) % NREQ;
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = PW'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/det_share_sched.sv
// Time-shares one 3-byte sequence detector between NREQ byte-stream requesters:
// arbitrate, clear the detector, stream the burst, then return hit/abort.
module det_share_sched
  import det_share_pkg::*;
#(
  parameter int         NREQ      = 2,
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              det_reset,
  output logic [7:0]        det_in,
  input  logic              det_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_abort
);

  localparam int              PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]      MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);
  localparam logic [1:0]      DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t          state_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   owner_r;
  logic [7:0]      count_r;
  logic [1:0]      drain_cnt_r;
  logic            abort_r;

  logic [NREQ-1:0] arb_grant_s;
  logic [PW-1:0]   arb_idx_s;
  logic            accept_s;
  logic            owner_last_s;
  logic [7:0]      owner_byte_s;
  logic [7:0]      count_next_s;
  logic [PW-1:0]   rr_next_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Owner handshake, byte select, next byte count and next round-robin pointer
  always_comb begin
    owner_byte_s = req_data[int'(owner_r)*8 +: 8];
    owner_last_s = req_last[owner_r];
    accept_s     = req_valid[owner_r] & req_ready[owner_r];
    count_next_s = count_r + 8'd1;
    if (owner_r == LAST_IDX) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = owner_r + PW'(1);
    end
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      count_r     <= 8'd0;
      drain_cnt_r <= 2'd0;
      abort_r     <= 1'b0;
      grant       <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_hit     <= 1'b0;
      rsp_abort   <= 1'b0;
      det_reset   <= 1'b1;
      det_in      <= IDLE_BYTE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          det_reset <= 1'b0;
          det_in    <= IDLE_BYTE;
          if (|req_valid) begin
            grant     <= arb_grant_s;
            owner_r   <= arb_idx_s;
            det_reset <= 1'b1;
            state_r   <= ST_CLR;
          end
        end
        ST_CLR: begin
          det_reset <= 1'b0;
          det_in    <= IDLE_BYTE;
          count_r   <= 8'd0;
          abort_r   <= 1'b0;
          req_ready <= ONE_HOT0 << owner_r;
          state_r   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept_s) begin
            det_in  <= owner_byte_s;
            count_r <= count_next_s;
            if (owner_last_s) begin
              req_ready   <= '0;
              drain_cnt_r <= 2'd0;
              state_r     <= ST_DRAIN;
            end else if (count_next_s == MAX_LEN_B) begin
              // Over-long burst: stop accepting; the requester drops the rest
              abort_r     <= 1'b1;
              req_ready   <= '0;
              drain_cnt_r <= 2'd0;
              state_r     <= ST_DRAIN;
            end
          end else begin
            // Gap bytes are deliberately forwarded and break the sequence
            det_in <= IDLE_BYTE;
          end
        end
        ST_DRAIN: begin
          det_in <= IDLE_BYTE;
          if (drain_cnt_r == DRAIN_LAST) begin
            rsp_hit   <= det_out;
            rsp_abort <= abort_r;
            rsp_valid <= grant;
            state_r   <= ST_RESP;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          grant     <= '0;
          rr_ptr_r  <= rr_next_s;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det_share_sched.sv
// Self-checking bench: burst-level reference model plus per-cycle protocol checks.
module tb_det_share_sched;
  import det_share_pkg::*;

  localparam int         NREQ    = 2;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] IDLE    = 8'h00;

  typedef struct packed {logic v; logic [7:0] d; logic l;} item_t;
  typedef struct {int owner; bit hit; bit abort; int nacc;} exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              det_reset;
  logic [7:0]        det_in;
  logic              det_out;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_hit;
  logic              rsp_abort;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  item_t      drv_q [NREQ][$];
  exp_t       exp_q [$];
  logic [7:0] din_log [$];
  int         acc_cnt = 0;
  int         rsp_count = 0;

  det_share_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .IDLE_BYTE(IDLE)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .det_reset (det_reset),
    .det_in    (det_in),
    .det_out   (det_out),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_abort (rsp_abort)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Environment: the shared detector (sticky flag after 1F,B2,3C; sync clear)
  logic [1:0] dm_state;
  always @(posedge clock) begin
    if (det_reset) begin
      dm_state <= 2'd0;
      det_out  <= 1'b0;
    end else begin
      if (dm_state == 2'd2 && det_in == SEQ_BYTE2) det_out <= 1'b1;
      if (det_in == SEQ_BYTE0) dm_state <= 2'd1;
      else if (dm_state == 2'd1 && det_in == SEQ_BYTE1) dm_state <= 2'd2;
      else dm_state <= 2'd0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic item_t itm(input logic v, input logic [7:0] d, input logic l);
    return {v, d, l};
  endfunction

  // Burst-level model: what the detector sees, and the response it must give
  function automatic exp_t model(input int owner, input item_t items[$]);
    exp_t       e;
    logic [7:0] s [$];
    int         n = 0;
    e.owner = owner; e.abort = 1'b0; e.hit = 1'b0;
    for (int i = 0; i < items.size(); i++) begin
      if (!items[i].v) begin
        s.push_back(IDLE);
      end else begin
        s.push_back(items[i].d);
        n++;
        if (items[i].l) break;
        if (n == MAX_LEN) begin e.abort = 1'b1; break; end
      end
    end
    for (int i = 0; i + 2 < s.size(); i++)
      if (s[i] == SEQ_BYTE0 && s[i+1] == SEQ_BYTE1 && s[i+2] == SEQ_BYTE2) e.hit = 1'b1;
    e.nacc = n;
    return e;
  endfunction

  task automatic start_burst(input int r, input item_t items[$]);
    foreach (items[i]) drv_q[r].push_back(items[i]);
    exp_q.push_back(model(r, items));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    chk(name, int'(n < budget), 1);
    repeat (3) @(posedge clock);
    #2;
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, din_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < din_log.size(); i++)
      chk(name, int'(din_log[i]), int'(exp[i]));
  endtask

  // Requester driver: hold each item until consumed by a ready cycle
  initial begin : driver
    logic [NREQ-1:0] rdy, abt;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      for (int r = 0; r < NREQ; r++) begin
        if (drv_q[r].size() > 0) begin
          req_valid[r] = drv_q[r][0].v;
          req_data[8*r +: 8] = drv_q[r][0].d;
          req_last[r] = drv_q[r][0].l;
        end else begin
          req_valid[r] = 1'b0;
          req_data[8*r +: 8] = 8'h00;
          req_last[r] = 1'b0;
        end
      end
      @(negedge clock);
      for (int r = 0; r < NREQ; r++) begin
        rdy[r] = req_ready[r];
        abt[r] = rsp_valid[r] & rsp_abort;
      end
      @(posedge clock);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (abt[r]) drv_q[r].delete();
        else if (rdy[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
      end
    end
  end

  // Compare process: protocol rules every cycle, burst responses against the model
  initial begin : compare
    logic [NREQ-1:0] prev_grant;
    logic            prev_acc, acc;
    logic [7:0]      prev_byte, abyte;
    int              since_grant, last_acc_cyc;
    exp_t            e;
    prev_grant = '0; prev_acc = 1'b0; prev_byte = IDLE; since_grant = 0; last_acc_cyc = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_grant = '0; prev_acc = 1'b0; prev_byte = IDLE; acc_cnt = 0; since_grant = 0;
      end else begin
        chk("det_in", int'(det_in), prev_acc ? int'(prev_byte) : int'(IDLE));
        chk("grant_onehot0", int'($countones(grant) <= 1), 1);
        chk("ready_in_grant", int'(req_ready & ~grant), 0);
        if (prev_grant == '0 && grant != '0) begin
          chk("clr_det_reset", int'(det_reset), 1);
          chk("clr_ready", int'(req_ready), 0);
          if (exp_q.size() > 0) chk("grant_owner", int'(grant), 1 << exp_q[0].owner);
          else chk("grant_unexpected", int'(grant), 0);
          since_grant = 0; acc_cnt = 0; din_log.delete();
        end else if (grant != '0) begin
          chk("det_reset_pulse", int'(det_reset), 0);
          if (since_grant == 1) chk("first_ready", int'(req_ready), int'(grant));
        end
        if (grant != '0) begin
          din_log.push_back(det_in);
          since_grant++;
        end
        if (rsp_valid != '0) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_owner", int'(rsp_valid), 1 << e.owner);
            chk("rsp_hit", int'(rsp_hit), int'(e.hit));
            chk("rsp_abort", int'(rsp_abort), int'(e.abort));
            chk("rsp_nacc", acc_cnt, e.nacc);
            chk("rsp_latency", cyc - last_acc_cyc, 3);
            rsp_count++;
          end else begin
            chk("rsp_unexpected", int'(rsp_valid), 0);
          end
        end
        acc = 1'b0; abyte = IDLE;
        for (int r = 0; r < NREQ; r++)
          if (req_valid[r] && req_ready[r]) begin acc = 1'b1; abyte = req_data[8*r +: 8]; end
        if (acc) begin acc_cnt++; last_acc_cyc = cyc; end
        prev_acc = acc; prev_byte = abyte; prev_grant = grant;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    item_t      b [$];
    logic [7:0] lg [$];
    exp_t       e;
    int         n, saved;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_grant", int'(grant), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_hit", int'(rsp_hit), 0);
    chk("rst_rsp_abort", int'(rsp_abort), 0);
    chk("rst_det_reset", int'(det_reset), 1);
    chk("rst_det_in", int'(det_in), int'(IDLE));
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_det_reset", int'(det_reset), 1);
    @(negedge clock);
    chk("idle_det_reset", int'(det_reset), 0);
    @(posedge clock); #2;

    // 1: r0 sends the full sequence back-to-back
    b = '{itm(1'b1, 8'h1F, 1'b0), itm(1'b1, 8'hB2, 1'b0), itm(1'b1, 8'h3C, 1'b1)};
    e = model(0, b);
    chk("t1_model_hit", int'(e.hit), 1);
    start_burst(0, b);
    wait_done("t1_done", 100);
    lg = '{8'h00, 8'h00, 8'h1F, 8'hB2, 8'h3C, 8'h00, 8'h00};
    check_log("t1_det_in_log", lg);
    chk("t1_hit_held", int'(rsp_hit), 1);

    // 2: r1 sequence broken by a gap cycle
    b = '{itm(1'b1, 8'h1F, 1'b0), itm(1'b0, 8'h00, 1'b0), itm(1'b1, 8'hB2, 1'b0), itm(1'b1, 8'h3C, 1'b1)};
    e = model(1, b);
    chk("t2_model_hit", int'(e.hit), 0);
    start_burst(1, b);
    wait_done("t2_done", 100);
    lg = '{8'h00, 8'h00, 8'h1F, 8'h00, 8'hB2, 8'h3C, 8'h00, 8'h00};
    check_log("t2_det_in_log", lg);

    // 3: both requesters valid from reset release; served 0 then 1
    reset = 1'b1;
    b = '{itm(1'b1, 8'h1F, 1'b0), itm(1'b1, 8'hB2, 1'b0), itm(1'b1, 8'h3C, 1'b1)};
    start_burst(0, b);
    start_burst(1, b);
    saved = rsp_count;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_done("t3_done", 200);
    chk("t3_rsp_count", rsp_count - saved, 2);

    // 4: over-long burst aborts after MAX_LEN bytes
    b.delete();
    for (int i = 0; i < 17; i++) b.push_back(itm(1'b1, 8'(64 + i), 1'b0));
    e = model(0, b);
    chk("t4_model_nacc", e.nacc, 16);
    chk("t4_model_abort", int'(e.abort), 1);
    start_burst(0, b);
    wait_done("t4_done", 200);
    chk("t4_abort_held", int'(rsp_abort), 1);
    chk("t4_hit_held", int'(rsp_hit), 0);
    chk("t4_ready_idle", int'(req_ready), 0);

    // 5: detector clear between owners wipes the sticky flag
    b = '{itm(1'b1, 8'h1F, 1'b0), itm(1'b1, 8'hB2, 1'b0), itm(1'b1, 8'h3C, 1'b1)};
    start_burst(0, b);
    wait_done("t5a_done", 100);
    b = '{itm(1'b1, 8'h3C, 1'b1)};
    e = model(1, b);
    chk("t5_model_hit", int'(e.hit), 0);
    start_burst(1, b);
    wait_done("t5b_done", 100);
    chk("t5_hit_cleared", int'(rsp_hit), 0);

    // 6: reset after the 2nd accepted byte drops the burst silently
    b = '{itm(1'b1, 8'h1F, 1'b0), itm(1'b1, 8'hB2, 1'b0), itm(1'b1, 8'h3C, 1'b1)};
    start_burst(0, b);
    saved = rsp_count;
    n = 0;
    while (acc_cnt != 2 && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    chk("t6_two_accepts", int'(n < 100), 1);
    reset = 1'b1;
    drv_q[0].delete();
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_grant", int'(grant), 0);
    chk("t6_rsp_valid", int'(rsp_valid), 0);
    chk("t6_det_reset", int'(det_reset), 1);
    chk("t6_ready", int'(req_ready), 0);
    repeat (10) @(posedge clock);
    #2;
    chk("t6_no_rsp", rsp_count, saved);
    start_burst(1, b);
    wait_done("t6_after_done", 100);
    chk("t6_after_rsp", rsp_count - saved, 1);
    chk("t6_after_hit", int'(rsp_hit), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
